// File: rtl/ps2_key_defs.sv
// Shared definitions for the PS/2 key tracker: scancodes, source/button
// indices, event field widths and the scancode/button mapping helpers.
package ps2_key_defs;

  localparam int unsigned NUM_BTN   = 8;
  localparam int unsigned NUM_SRC   = 12;
  localparam int unsigned EVT_IDX_W = 3;
  localparam int unsigned EVT_W     = EVT_IDX_W + 1;

  // Set-2 make codes (expand prefix is ignored, so keypad and arrows alias)
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_J     = 8'h3B;
  localparam logic [7:0] SC_K     = 8'h42;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_KP8   = 8'h75;
  localparam logic [7:0] SC_KP2   = 8'h72;
  localparam logic [7:0] SC_KP4   = 8'h6B;
  localparam logic [7:0] SC_KP6   = 8'h74;

  localparam int unsigned BTN_UP     = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_LEFT   = 2;
  localparam int unsigned BTN_RIGHT  = 3;
  localparam int unsigned BTN_A      = 4;
  localparam int unsigned BTN_B      = 5;
  localparam int unsigned BTN_START  = 6;
  localparam int unsigned BTN_SELECT = 7;

  localparam int unsigned SRC_W     = 0;
  localparam int unsigned SRC_KP8   = 1;
  localparam int unsigned SRC_S     = 2;
  localparam int unsigned SRC_KP2   = 3;
  localparam int unsigned SRC_A     = 4;
  localparam int unsigned SRC_KP4   = 5;
  localparam int unsigned SRC_D     = 6;
  localparam int unsigned SRC_KP6   = 7;
  localparam int unsigned SRC_J     = 8;
  localparam int unsigned SRC_K     = 9;
  localparam int unsigned SRC_ENTER = 10;
  localparam int unsigned SRC_SPACE = 11;

  // One-hot source select for a scancode; all zeros for unmapped codes.
  function automatic logic [NUM_SRC-1:0] src_onehot(input logic [7:0] code);
    logic [NUM_SRC-1:0] oh;
    oh = '0;
    case (code)
      SC_W:     oh[SRC_W]     = 1'b1;
      SC_KP8:   oh[SRC_KP8]   = 1'b1;
      SC_S:     oh[SRC_S]     = 1'b1;
      SC_KP2:   oh[SRC_KP2]   = 1'b1;
      SC_A:     oh[SRC_A]     = 1'b1;
      SC_KP4:   oh[SRC_KP4]   = 1'b1;
      SC_D:     oh[SRC_D]     = 1'b1;
      SC_KP6:   oh[SRC_KP6]   = 1'b1;
      SC_J:     oh[SRC_J]     = 1'b1;
      SC_K:     oh[SRC_K]     = 1'b1;
      SC_ENTER: oh[SRC_ENTER] = 1'b1;
      SC_SPACE: oh[SRC_SPACE] = 1'b1;
      default:  oh = '0;
    endcase
    return oh;
  endfunction

  // A button is held while any of its sources is held.
  function automatic logic [NUM_BTN-1:0] src_to_btn(input logic [NUM_SRC-1:0] src);
    logic [NUM_BTN-1:0] btn;
    btn = '0;
    btn[BTN_UP]     = src[SRC_W] | src[SRC_KP8];
    btn[BTN_DOWN]   = src[SRC_S] | src[SRC_KP2];
    btn[BTN_LEFT]   = src[SRC_A] | src[SRC_KP4];
    btn[BTN_RIGHT]  = src[SRC_D] | src[SRC_KP6];
    btn[BTN_A]      = src[SRC_J];
    btn[BTN_B]      = src[SRC_K];
    btn[BTN_START]  = src[SRC_ENTER];
    btn[BTN_SELECT] = src[SRC_SPACE];
    return btn;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers and a sticky overflow flag.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module key_event_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             overflow_q;
  logic             do_push, do_pop;

  // Occupancy flags and accepted push/pop decisions.
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Pointer, storage and overflow state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !do_push) overflow_q <= 1'b1;
    end
  end

  assign rdata    = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow = overflow_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// Maps decoded PS/2 scancodes onto 8 game buttons, keeps a held bitmap with
// press/release pulses and a stuck-key watchdog.
// Optional event FIFO enabled by defining PS2_KEY_EVENT_FIFO_EN.
module ps2_key_tracker
  import ps2_key_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd0,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         key_data,
  input  logic               key_ready,
  output logic [NUM_BTN-1:0] btn_held,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               evt_valid,
  output logic [EVT_W-1:0]   evt_data,
  input  logic               evt_pop,
  output logic               evt_overflow
);

  logic [NUM_SRC-1:0] src_q, src_d, hit;
  logic [31:0]        cnt_q, cnt_d;
  logic               wd_clr_q;  // last source change was a watchdog clear
  logic               expire;
  logic [NUM_BTN-1:0] held_q, held_d, press_q, release_q;
  logic               unused_expand;

  assign unused_expand = key_data[9];

  // Source bit update from scancodes, watchdog expiry and idle counter.
  always_comb begin
    hit    = src_onehot(key_data[7:0]);
    expire = 1'b0;
    if (TIMEOUT_CYCLES != 0) begin
      expire = (|src_q) && !key_ready && (cnt_q == TIMEOUT_CYCLES - 32'd1);
    end
    src_d = src_q;
    if (key_ready) begin
      src_d = key_data[8] ? (src_q & ~hit) : (src_q | hit);
    end else if (expire) begin
      src_d = '0;
    end
    if (key_ready || !(|src_q) || expire) cnt_d = '0;
    else cnt_d = cnt_q + 32'd1;
    held_d = src_to_btn(src_q);
  end

  // Source, counter, held bitmap and edge pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q     <= '0;
      cnt_q     <= '0;
      wd_clr_q  <= 1'b0;
      held_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      src_q     <= src_d;
      cnt_q     <= cnt_d;
      wd_clr_q  <= expire;
      held_q    <= held_d;
      press_q   <= held_d & ~held_q;
      release_q <= ~held_d & held_q;
    end
  end

  assign btn_held    = held_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef PS2_KEY_EVENT_FIFO_EN
  logic [NUM_BTN-1:0]   chg;
  logic [EVT_IDX_W-1:0] evt_idx;
  logic                 evt_push;
  logic [EVT_W-1:0]     evt_wdata;
  logic                 fifo_empty;
  logic                 unused_fifo_full;

  // A scancode changes at most one button per cycle; encode it as an event.
  always_comb begin
    chg     = held_d ^ held_q;
    evt_idx = '0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      if (chg[i]) evt_idx = i[EVT_IDX_W-1:0];
    end
    evt_push  = (|chg) && !wd_clr_q;
    evt_wdata = {held_q[evt_idx], evt_idx};
  end

  key_event_fifo #(
    .WIDTH(EVT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (evt_push),
    .wdata    (evt_wdata),
    .pop      (evt_pop),
    .rdata    (evt_data),
    .full     (unused_fifo_full),
    .empty    (fifo_empty),
    .overflow (evt_overflow)
  );

  assign evt_valid = !fifo_empty;
`else
  logic [33:0] unused_cfg;

  assign unused_cfg   = {evt_pop, wd_clr_q, 32'(FIFO_DEPTH)};
  assign evt_valid    = 1'b0;
  assign evt_data     = '0;
  assign evt_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomized self-checking bench for ps2_key_tracker with a behavioural model.
module tb_ps2_key_tracker;

  localparam int unsigned TO    = 100;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] key_data = '0;
  logic       key_ready = 1'b0;
  logic       evt_pop = 1'b0;
  logic [7:0] btn_held, btn_press, btn_release;
  logic       evt_valid, evt_overflow;
  logic [3:0] evt_data;

  int n_vec = 0;
  int n_err = 0;

  ps2_key_tracker #(
    .TIMEOUT_CYCLES(TO),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_data    (key_data),
    .key_ready   (key_ready),
    .btn_held    (btn_held),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .evt_valid   (evt_valid),
    .evt_data    (evt_data),
    .evt_pop     (evt_pop),
    .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  // Key table: scancode and the button it drives.
  logic [7:0] code_tab [12] = '{8'h1D, 8'h75, 8'h1B, 8'h72, 8'h1C, 8'h6B,
                                8'h23, 8'h74, 8'h3B, 8'h42, 8'h5A, 8'h29};
  int         btn_tab  [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};
  logic [7:0] pool     [14] = '{8'h1D, 8'h75, 8'h1B, 8'h72, 8'h1C, 8'h6B, 8'h23,
                                8'h74, 8'h3B, 8'h42, 8'h5A, 8'h29, 8'h00, 8'h12};

  // Model state: ideal per-key held bits, idle count, button history, queue.
  logic [11:0] s_m = '0;
  int          idle_m = 0;
  logic [7:0]  b1 = '0, b2 = '0, b3 = '0;
  bit          w1 = 1'b0;
  logic [3:0]  q_m [$];
  bit          ovf_m = 1'b0;
  bit          any_m, exp_m, pop_m, push_m;
  int          k_m;
  logic [3:0]  e_m;
  logic [7:0]  d_m;

  function automatic int src_of(input logic [7:0] code);
    for (int i = 0; i < 12; i++) if (code_tab[i] == code) return i;
    return -1;
  endfunction

  function automatic logic [7:0] btn_of(input logic [11:0] s);
    logic [7:0] b = '0;
    for (int i = 0; i < 12; i++) if (s[i]) b[btn_tab[i]] = 1'b1;
    return b;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      s_m = '0; idle_m = 0; b1 = '0; b2 = '0; b3 = '0; w1 = 1'b0;
      q_m.delete(); ovf_m = 1'b0;
    end else begin
      // Event queue: a button change caused by a key shows up with its pulse.
      pop_m  = evt_pop && (q_m.size() != 0);
      push_m = (b1 != b2) && !w1;
      d_m    = b1 ^ b2;
      e_m    = '0;
      for (int i = 0; i < 8; i++) if (d_m[i]) e_m = {b2[i], 3'(i)};
`ifdef PS2_KEY_EVENT_FIFO_EN
      if (push_m && q_m.size() == DEPTH && !pop_m) ovf_m = 1'b1;
      else begin
        if (pop_m) void'(q_m.pop_front());
        if (push_m) q_m.push_back(e_m);
      end
`endif
      b3 = b2;
      b2 = b1;
      any_m = (s_m != 0);
      exp_m = any_m && !key_ready && (idle_m == TO - 1);
      if (key_ready) begin
        k_m = src_of(key_data[7:0]);
        if (k_m >= 0) s_m[k_m] = !key_data[8];
        idle_m = 0;
      end else if (exp_m) begin
        s_m = '0;
        idle_m = 0;
      end else if (any_m) idle_m++;
      else idle_m = 0;
      b1 = btn_of(s_m);
      w1 = exp_m;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("held", btn_held, b2);
    chk("press", btn_press, b2 & ~b3);
    chk("release", btn_release, ~b2 & b3);
`ifdef PS2_KEY_EVENT_FIFO_EN
    chk("evt_valid", {7'd0, evt_valid}, {7'd0, q_m.size() != 0});
    if (q_m.size() != 0) chk("evt_data", {4'd0, evt_data}, {4'd0, q_m[0]});
    chk("evt_overflow", {7'd0, evt_overflow}, {7'd0, ovf_m});
`else
    chk("evt_valid", {7'd0, evt_valid}, 8'd0);
    chk("evt_data", {4'd0, evt_data}, 8'd0);
    chk("evt_overflow", {7'd0, evt_overflow}, 8'd0);
`endif
  end

  task automatic step(input logic rdy, input logic [9:0] d, input logic pop);
    @(posedge clk);
    #1;
    key_ready = rdy;
    key_data  = d;
    evt_pop   = pop;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 10'h000, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; key_ready = 1'b0; evt_pop = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100_000_000;
    $display("FAIL time_limit: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_held", btn_held, 8'h00);

    // Single make of W: press pulse exactly two cycles later.
    step(1'b1, 10'h01D, 1'b0);
    tick(1);
    @(negedge clk);
    chk("w_press_early", btn_press, 8'h00);
    tick(1);
    @(negedge clk);
    chk("w_press", btn_press, 8'h01);
    chk("w_held", btn_held, 8'h01);
    tick(1);
    @(negedge clk);
    chk("w_press_once", btn_press, 8'h00);

    // Typematic repeats then break.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 10'h01D, 1'b0);
      tick(2);
    end
    step(1'b1, 10'h11D, 1'b0);
    tick(2);
    @(negedge clk);
    chk("w_release", btn_release, 8'h01);
    tick(3);

    // Two sources on UP.
    step(1'b1, 10'h01D, 1'b0); tick(2);
    step(1'b1, 10'h275, 1'b0); tick(2);
    step(1'b1, 10'h11D, 1'b0); tick(3);
    @(negedge clk);
    chk("up_two_src", btn_held, 8'h01);
    step(1'b1, 10'h375, 1'b0); tick(4);
    @(negedge clk);
    chk("up_released", btn_held, 8'h00);

    // Watchdog expiry on Enter.
    do_reset();
    step(1'b1, 10'h05A, 1'b0);
    tick(102);
    @(negedge clk);
    chk("wd_release", btn_release, 8'h40);
    tick(3);

    // Key arriving in the expiry cycle wins.
    do_reset();
    step(1'b1, 10'h05A, 1'b0);
    tick(99);
    step(1'b1, 10'h05A, 1'b0);
    tick(2);
    @(negedge clk);
    chk("wd_cancel", btn_release, 8'h00);
    chk("wd_cancel_held", btn_held, 8'h40);
    step(1'b1, 10'h15A, 1'b0);
    tick(4);

`ifdef PS2_KEY_EVENT_FIFO_EN
    // Fill the FIFO, then push while popping, then overflow.
    do_reset();
    step(1'b1, 10'h03B, 1'b0); tick(3);
    step(1'b1, 10'h13B, 1'b0); tick(3);
    step(1'b1, 10'h042, 1'b0); tick(3);
    step(1'b1, 10'h142, 1'b0); tick(3);
    step(1'b1, 10'h05A, 1'b0);
    step(1'b0, 10'h000, 1'b1);
    tick(3);
    @(negedge clk);
    chk("fifo_no_ovf", {7'd0, evt_overflow}, 8'h00);
    chk("fifo_head", {4'd0, evt_data}, 8'h0C);
    step(1'b1, 10'h15A, 1'b0); tick(3);
    @(negedge clk);
    chk("fifo_ovf", {7'd0, evt_overflow}, 8'h01);
`endif

    // Reset in the cycle after a key.
    do_reset();
    step(1'b1, 10'h03B, 1'b0);
    @(posedge clk);
    #1;
    key_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_press", btn_press, 8'h00);
    chk("rst_held", btn_held, 8'h00);
    chk("rst_valid", {7'd0, evt_valid}, 8'h00);

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 60) begin
        step(1'b1, {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    pool[$urandom_range(0, 13)]}, 1'($urandom_range(0, 2) == 0));
      end else if (r < 63) begin
        tick(110);
      end else if (r < 64) begin
        do_reset();
      end else begin
        step(1'b0, 10'h000, 1'($urandom_range(0, 2) == 0));
      end
    end
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Consumes decoded PS/2 scancode words and their 1-cycle `ready` strobe from the upstream PS/2 receiver. Maps the scancodes onto the 8 console game buttons and keeps a debounced held-state bitmap. Produces registered press/release edge pulses for the game logic, plus a stuck-key watchdog. An optional event FIFO lets software-style consumers pop discrete button events.

Parameters:
TIMEOUT_CYCLES, 32'd0, idle cycles with no `key_ready` before all held keys are force-cleared; 0 disables the watchdog.
FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16; used only with the macro.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
key_data  in  10  scancode word {expand, break, code[7:0]}.
key_ready  in  1  1-cycle strobe; `key_data` is valid in that cycle.
btn_held  out  8  current button state; bit 1 = held.
btn_press  out  8  1-cycle pulse per button on a 0->1 transition.
btn_release  out  8  1-cycle pulse per button on a 1->0 transition.
evt_valid  out  1  FIFO non-empty.
evt_data  out  4  head entry {release, btn_idx[2:0]}.
evt_pop  in  1  pops the head entry when `evt_valid` is 1.
evt_overflow  out  1  sticky; set when a push is dropped.

Behaviour:
- Reset: every output is 0, all source bits are 0, the FIFO is empty and the timeout counter is 0.
- Reset asserted mid-operation clears everything on the next edge; no event survives it.
- Lookup uses `code` only; `expand` (bit 9) is ignored. Arrow and keypad codes therefore alias.
- There are 12 source keys, each with its own held bit:
  - W 1D, E0 75 / 75 -> UP (idx 0)
  - S 1B, 72 -> DOWN (idx 1)
  - A 1C, 6B -> LEFT (idx 2)
  - D 23, 74 -> RIGHT (idx 3)
  - J 3B -> BTN_A (idx 4)
  - K 42 -> BTN_B (idx 5)
  - Enter 5A -> START (idx 6)
  - Space 29 -> SELECT (idx 7)
- Cycle N, `key_ready` high with a mapped code: the source bit is set to ~break at N+1. Unmapped codes are ignored.
- `btn_held[i]` is the OR of its sources, registered, and becomes valid at N+2.
- `btn_press` and `btn_release` come from comparing `btn_held` with its previous value, so they pulse at N+2 for exactly one cycle.
- Typematic repeats (make while already held) cause no state change and no pulse. A break for a key not held is likewise a no-op.
- Two sources on one button: the button stays held until both are released.
- Watchdog (TIMEOUT_CYCLES != 0):
  - A 32-bit counter increments every cycle while any source bit is set.
  - The counter resets to 0 on `key_ready` or when no sources are set.
  - When the count reaches TIMEOUT_CYCLES-1, all source bits clear on the next edge, which produces `btn_release` pulses for every held button.
  - If `key_ready` arrives in the same cycle as expiry, the scancode update wins and the counter resets.
- Without the macro: `evt_valid`, `evt_data` and `evt_overflow` are constant 0, and `evt_pop` is ignored.

Optional Feature:
PS2_KEY_EVENT_FIFO_EN
- Defined:
  - Each scancode-driven change of a `btn_held` bit pushes {release, idx} into the FIFO in the same cycle as the pulse.
  - Watchdog clears push nothing.
  - A make and a break cannot coincide, so there is at most one push per cycle.
  - FIFO full and push without pop: the entry is dropped and `evt_overflow` is set.
  - Full with push and pop in the same cycle: both occur, with no overflow.
  - Empty with `evt_pop`: no-op.
  - `evt_data` is the registered head entry; it updates the cycle after a pop.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide with a wrap bit.
- Undefined: no FIFO storage is synthesised; the outputs are tied as stated in Behaviour.

Decomposition:
- Shared package/defs header `ps2_key_defs`:
  - scancode constants (SC_W ... SC_SPACE, SC_KP8/2/4/6)
  - button index constants BTN_UP..BTN_SELECT
  - event field widths
- Sub-module `key_event_fifo`: generic synchronous FIFO (WIDTH, DEPTH) with push, pop, full, empty and overflow. It is instantiated only under the macro.

Test Plan:
- Apply reset, then `key_data`=0x01D with a `key_ready` pulse -> `btn_held`=0x01, `btn_press`=0x01 for one cycle at +2, FIFO entry 0x0.
- Send 0x01D three more times (typematic), then 0x11D -> no extra pulses; `btn_release`=0x01 once; FIFO holds 0x0 then 0x8.
- Send 0x01D, then 0x275 (E0 75 make), then 0x11D -> `btn_held[0]` stays 1; a following 0x375 releases it with a single `btn_release` pulse.
- With TIMEOUT_CYCLES=100, hold 0x05A and idle -> `btn_release`=0x40 at expiry, FIFO unchanged. Repeat with `key_ready` arriving at cycle 99 -> no release.
- With the macro and FIFO_DEPTH=4, make/break J, K, Enter without popping -> 4 entries, 5th and 6th dropped, `evt_overflow`=1. Pop while full in the same cycle as a push -> no new overflow, count stays 4.
- Assert `rst` in the cycle after a `key_ready` for 0x03B -> no `btn_press` pulse, `btn_held`=0, `evt_valid`=0.
